knight_tour_solver: RTL and testbench

Parametrised knight's-tour engine. On `go` it searches an N×N board depth-first with full backtracking from a given start square. It records the chosen move sequence in an internal history memory that the move-replay logic reads back by index. Unlike the fixed 5×5 generation it supports configurable board size, explicit failure reporting and a busy indication.

---
 rtl/tour_pkg.sv | 46 ++++
 rtl/knight_tour_solver_if.sv | 19 +
 rtl/tour_move_gen.sv | 35 +++
 rtl/knight_tour_solver.sv | 137 +++++++++++++
 tb/tb_knight_tour_solver.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/tour_pkg.sv
// Shared types and move geometry for the knight's-tour engine.
package tour_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_POSSIBLE,
    ST_MAKE,
    ST_BACKUP,
    ST_DONE,
    ST_FAIL
  } state_t;

  // One-hot move codes; candidates are tried from MOVE_0 upward.
  localparam logic [7:0] MOVE_0 = 8'h01;  // (+1,+2)
  localparam logic [7:0] MOVE_1 = 8'h02;  // (-1,+2)
  localparam logic [7:0] MOVE_2 = 8'h04;  // (-2,+1)
  localparam logic [7:0] MOVE_3 = 8'h08;  // (-2,-1)
  localparam logic [7:0] MOVE_4 = 8'h10;  // (-1,-2)
  localparam logic [7:0] MOVE_5 = 8'h20;  // (+1,-2)
  localparam logic [7:0] MOVE_6 = 8'h40;  // (+2,-1)
  localparam logic [7:0] MOVE_7 = 8'h80;  // (+2,+1)

  // Column offset of a one-hot move; zero for anything not one-hot.
  function automatic logic signed [2:0] dx(input logic [7:0] m);
    case (m)
      MOVE_0, MOVE_5: return 3'sd1;
      MOVE_1, MOVE_4: return -3'sd1;
      MOVE_2, MOVE_3: return -3'sd2;
      MOVE_6, MOVE_7: return 3'sd2;
      default:        return 3'sd0;
    endcase
  endfunction

  // Row offset of a one-hot move; zero for anything not one-hot.
  function automatic logic signed [2:0] dy(input logic [7:0] m);
    case (m)
      MOVE_0, MOVE_1: return 3'sd2;
      MOVE_2, MOVE_7: return 3'sd1;
      MOVE_3, MOVE_6: return -3'sd1;
      MOVE_4, MOVE_5: return -3'sd2;
      default:        return 3'sd0;
    endcase
  endfunction

endpackage

// File: rtl/knight_tour_solver_if.sv
// Control/readback bundle between a host and the knight's-tour engine.
interface knight_tour_solver_if #(
  parameter int BOARD = 5
);
  localparam int COORD_W = $clog2(BOARD);
  localparam int IDX_W   = $clog2(BOARD * BOARD);

  logic               go;
  logic [COORD_W-1:0] x_start;
  logic [COORD_W-1:0] y_start;
  logic [IDX_W-1:0]   indx;
  logic [7:0]         move;
  logic               busy;
  logic               done;
  logic               fail;

  modport master (output go, x_start, y_start, indx, input move, busy, done, fail);
  modport slave  (input go, x_start, y_start, indx, output move, busy, done, fail);
endinterface

// File: rtl/tour_move_gen.sv
// Legal-move mask for a knight at (x,y): target on the board and not yet visited.
module tour_move_gen
  import tour_pkg::*;
#(
  parameter  int BOARD   = 5,
  localparam int COORD_W = $clog2(BOARD),
  localparam int NSQ     = BOARD * BOARD,
  localparam int IDX_W   = $clog2(NSQ)
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [NSQ-1:0]     visited,
  output logic [7:0]         legal
);
  localparam int CW1 = COORD_W + 1;

  for (genvar gi = 0; gi < 8; gi++) begin : g_dir
    localparam logic [7:0] DIR = 8'(1 << gi);
    logic signed [COORD_W:0] nx;
    logic signed [COORD_W:0] ny;
    logic                    inb;
    logic [IDX_W-1:0]        sq;

    // Signed target coordinate; overflow past the top wraps negative and is rejected.
    always_comb begin
      nx  = $signed({1'b0, x}) + CW1'(dx(DIR));
      ny  = $signed({1'b0, y}) + CW1'(dy(DIR));
      inb = !nx[COORD_W] && !ny[COORD_W] &&
            (int'(nx[COORD_W-1:0]) < BOARD) && (int'(ny[COORD_W-1:0]) < BOARD);
      sq  = IDX_W'(int'(ny[COORD_W-1:0]) * BOARD + int'(nx[COORD_W-1:0]));
    end

    assign legal[gi] = inb & ~visited[sq];
  end
endmodule

// File: rtl/knight_tour_solver.sv
// Knight's-tour engine: depth-first search with full backtracking and move-history readback.
module knight_tour_solver
  import tour_pkg::*;
#(
  parameter  int BOARD   = 5,
  localparam int COORD_W = $clog2(BOARD),
  localparam int NMOVES  = BOARD * BOARD - 1,
  localparam int IDX_W   = $clog2(BOARD * BOARD)
) (
  input logic clk,
  input logic rst_n,
  knight_tour_solver_if.slave bus
);
  localparam int NSQ = BOARD * BOARD;
  localparam int HW  = $clog2(NMOVES);

  state_t             state_reg, state_next;
  logic [NSQ-1:0]     visited;
  logic [7:0]         poss [NMOVES];
  logic [7:0]         hist [NMOVES];
  logic [IDX_W-1:0]   depth;
  logic [7:0]         try_move;
  logic [COORD_W-1:0] x, y;

  logic [7:0]         legal, cand, undo_move;
  logic [IDX_W-1:0]   depth_inc, depth_dec;
  logic [HW-1:0]      cur_slot, undo_slot;
  logic [COORD_W-1:0] fwd_x, fwd_y, back_x, back_y;
  logic               start_ok;

  function automatic logic [IDX_W-1:0] sq_of(input logic [COORD_W-1:0] cx,
                                             input logic [COORD_W-1:0] cy);
    return IDX_W'(int'(cy) * BOARD + int'(cx));
  endfunction

  tour_move_gen #(.BOARD(BOARD)) u_move_gen (
    .x       (x),
    .y       (y),
    .visited (visited),
    .legal   (legal)
  );

  assign cur_slot  = depth[HW-1:0];
  assign depth_inc = depth + IDX_W'(1);
  assign depth_dec = depth - IDX_W'(1);
  assign undo_slot = depth_dec[HW-1:0];
  assign cand      = try_move & poss[cur_slot];
  assign undo_move = hist[undo_slot];
  // Moves are known to land on the board, so modular COORD_W-bit arithmetic is exact.
  assign fwd_x     = x + COORD_W'(dx(try_move));
  assign fwd_y     = y + COORD_W'(dy(try_move));
  assign back_x    = x - COORD_W'(dx(undo_move));
  assign back_y    = y - COORD_W'(dy(undo_move));
  assign start_ok  = (int'(bus.x_start) < BOARD) && (int'(bus.y_start) < BOARD);

  assign bus.busy = (state_reg == ST_INIT) || (state_reg == ST_POSSIBLE) ||
                    (state_reg == ST_MAKE) || (state_reg == ST_BACKUP);
  assign bus.done = (state_reg == ST_DONE);
  assign bus.fail = (state_reg == ST_FAIL);
  assign bus.move = (bus.indx < IDX_W'(NMOVES)) ? hist[bus.indx[HW-1:0]] : 8'h00;

  // State register; reset drops straight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state decision for the search walk.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_FAIL: if (bus.go) state_next = ST_INIT;
      ST_INIT:     state_next = start_ok ? ST_POSSIBLE : ST_FAIL;
      ST_POSSIBLE: state_next = ST_MAKE;
      ST_MAKE: begin
        if (|cand)                  state_next = (depth_inc == IDX_W'(NMOVES)) ? ST_DONE : ST_POSSIBLE;
        else if (try_move != MOVE_7) state_next = ST_MAKE;
        else if (depth == '0)        state_next = ST_FAIL;
        else                         state_next = ST_BACKUP;
      end
      ST_BACKUP: begin
        if (undo_move == MOVE_7) state_next = (depth_dec == '0) ? ST_FAIL : ST_BACKUP;
        else                     state_next = ST_MAKE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Board, history and cursor updates for each search step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      visited  <= '0;
      poss     <= '{default: 8'h00};
      hist     <= '{default: 8'h00};
      depth    <= '0;
      try_move <= '0;
      x        <= '0;
      y        <= '0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          visited <= '0;
          poss    <= '{default: 8'h00};
          hist    <= '{default: 8'h00};
          depth   <= '0;
          x       <= bus.x_start;
          y       <= bus.y_start;
          if (start_ok) visited[sq_of(bus.x_start, bus.y_start)] <= 1'b1;
        end
        ST_POSSIBLE: begin
          poss[cur_slot] <= legal;
          try_move       <= MOVE_0;
        end
        ST_MAKE: begin
          if (|cand) begin
            x                            <= fwd_x;
            y                            <= fwd_y;
            visited[sq_of(fwd_x, fwd_y)] <= 1'b1;
            hist[cur_slot]               <= try_move;
            depth                        <= depth_inc;
          end else if (try_move != MOVE_7) begin
            try_move <= try_move << 1;
          end
        end
        ST_BACKUP: begin
          visited[sq_of(x, y)] <= 1'b0;
          depth                <= depth_dec;
          x                    <= back_x;
          y                    <= back_y;
          hist[undo_slot]      <= 8'h00;
          if (undo_move != MOVE_7) try_move <= undo_move << 1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_knight_tour_solver.sv
// Directed/randomised bench: tours are validated by replaying the stored moves on a board model.
module tb_knight_tour_solver;
  localparam int BUDGET = 400000;

  logic clk = 1'b0;
  logic rst_n5, rst_n3;
  always #5 clk = ~clk;

  knight_tour_solver_if #(.BOARD(5)) if5 ();
  knight_tour_solver_if #(.BOARD(3)) if3 ();

  knight_tour_solver #(.BOARD(5)) dut5 (.clk(clk), .rst_n(rst_n5), .bus(if5));
  knight_tour_solver #(.BOARD(3)) dut3 (.clk(clk), .rst_n(rst_n3), .bus(if3));

  int n_cmp = 0;
  int n_bad = 0;
  int dxt[8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int dyt[8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A board with a square that no knight move reaches cannot hold a tour.
  function automatic bit has_isolated(input int b);
    for (int sy = 0; sy < b; sy++) begin
      for (int sx = 0; sx < b; sx++) begin
        int deg;
        deg = 0;
        for (int k = 0; k < 8; k++) begin
          if (sx + dxt[k] >= 0 && sx + dxt[k] < b && sy + dyt[k] >= 0 && sy + dyt[k] < b) deg++;
        end
        if (deg == 0) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic go5(input int sx, input int sy);
    if5.x_start = sx[2:0];
    if5.y_start = sy[2:0];
    if5.go = 1'b1;
    tick(1);
    if5.go = 1'b0;
  endtask

  task automatic wait5(input string tag);
    int n;
    n = 0;
    while (if5.busy === 1'b1 && n < BUDGET) begin
      tick(1);
      n++;
    end
    check({tag, "_finished"}, if5.busy, 0);
  endtask

  task automatic hist_or5(output logic [7:0] acc);
    acc = 8'h00;
    for (int i = 0; i < 32; i++) begin
      if5.indx = 5'(i);
      #2;
      acc |= if5.move;
    end
    tick(1);
  endtask

  // Read all moves in random order, then walk them from the start on a 5x5 model board.
  task automatic replay5(input string tag, input int sx, input int sy);
    int ord[24];
    logic [7:0] mv[24];
    bit vis[25];
    int px, py, nx, ny, nvis, b, j, t;
    bit ok;
    for (int i = 0; i < 24; i++) ord[i] = i;
    for (int i = 23; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = ord[i]; ord[i] = ord[j]; ord[j] = t;
    end
    for (int i = 0; i < 24; i++) begin
      if5.indx = 5'(ord[i]);
      #2;
      mv[ord[i]] = if5.move;
    end
    foreach (vis[i]) vis[i] = 1'b0;
    px = sx; py = sy;
    vis[py * 5 + px] = 1'b1;
    nvis = 1;
    for (int k = 0; k < 24; k++) begin
      check($sformatf("%s_onehot%0d", tag, k), $countones(mv[k]), 1);
      b = -1;
      for (int i = 7; i >= 0; i--) if (mv[k][i]) b = i;
      ok = 1'b0;
      if (b >= 0) begin
        nx = px + dxt[b];
        ny = py + dyt[b];
        if (nx >= 0 && nx < 5 && ny >= 0 && ny < 5) begin
          if (!vis[ny * 5 + nx]) begin
            ok = 1'b1;
            vis[ny * 5 + nx] = 1'b1;
            nvis++;
            px = nx; py = ny;
          end
        end
      end
      check($sformatf("%s_step%0d", tag, k), ok, 1);
    end
    check({tag, "_cover"}, nvis, 25);
    if5.indx = 5'd24;
    #2;
    check({tag, "_idx24"}, if5.move, 0);
    if5.indx = 5'($urandom_range(31, 25));
    #2;
    check({tag, "_idx_hi"}, if5.move, 0);
    tick(1);
  endtask

  initial begin
    int bx, by, n;
    bit iso3;
    logic [7:0] acc;

    rst_n5 = 1'b0; rst_n3 = 1'b0;
    if5.go = 1'b0; if5.x_start = '0; if5.y_start = '0; if5.indx = 5'($urandom_range(23, 0));
    if3.go = 1'b0; if3.x_start = '0; if3.y_start = '0; if3.indx = '0;
    tick(3);
    check("rst_busy", if5.busy, 0);
    check("rst_done", if5.done, 0);
    check("rst_fail", if5.fail, 0);
    check("rst_move", if5.move, 0);
    check("rst3_busy", if3.busy, 0);
    rst_n5 = 1'b1; rst_n3 = 1'b1;
    tick(2);
    check("idle_busy", if5.busy, 0);

    // Off-board start: INIT then FAIL, nothing recorded.
    bx = int'($urandom_range(7, 5));
    by = int'($urandom_range(7, 0));
    $display("illegal start (%0d,%0d)", bx, by);
    go5(bx, by);
    check("ill_init_busy", if5.busy, 1);
    check("ill_init_fail", if5.fail, 0);
    tick(1);
    check("ill_fail", if5.fail, 1);
    check("ill_done", if5.done, 0);
    check("ill_busy", if5.busy, 0);
    hist_or5(acc);
    check("ill_hist", acc, 0);

    // Tour from centre, with a go pulse that must be ignored mid-search.
    go5(2, 2);
    check("t22_init_busy", if5.busy, 1);
    check("t22_init_fail", if5.fail, 0);
    n = int'($urandom_range(60, 10));
    tick(n);
    check("t22_mid_busy", if5.busy, 1);
    if5.x_start = 3'd0; if5.y_start = 3'd0; if5.go = 1'b1;
    tick(1);
    if5.go = 1'b0;
    check("t22_go_ignored", if5.busy, 1);
    $display("tour (2,2): extra go after %0d cycles", n);
    wait5("t22");
    check("t22_done", if5.done, 1);
    check("t22_fail", if5.fail, 0);
    replay5("t22", 2, 2);

    // 3x3: centre unreachable, search must report failure.
    iso3 = has_isolated(3);
    if3.x_start = 2'd0; if3.y_start = 2'd0; if3.go = 1'b1;
    tick(1);
    if3.go = 1'b0;
    n = 0;
    while (if3.busy === 1'b1 && n < BUDGET) begin
      tick(1);
      n++;
    end
    $display("tour 3x3 (0,0): ended after %0d cycles", n);
    check("b3_finished", if3.busy, 0);
    check("b3_fail", if3.fail, 32'(iso3));
    check("b3_done", if3.done, 32'(!iso3));
    acc = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if3.indx = 4'(i);
      #2;
      acc |= if3.move;
    end
    tick(1);
    check("b3_hist", acc, 0);

    // Asynchronous reset in the middle of a search, then a clean rerun.
    go5(0, 0);
    n = int'($urandom_range(300, 20));
    tick(n);
    if5.indx = 5'd0;
    #2;
    rst_n5 = 1'b0;
    #1;
    $display("reset mid-search after %0d cycles", n);
    check("arst_busy", if5.busy, 0);
    check("arst_done", if5.done, 0);
    check("arst_fail", if5.fail, 0);
    check("arst_move", if5.move, 0);
    tick(1);
    rst_n5 = 1'b1;
    tick(1);
    check("arst_idle", if5.busy, 0);
    go5(0, 0);
    wait5("t00");
    check("t00_done", if5.done, 1);
    check("t00_fail", if5.fail, 0);
    replay5("t00", 0, 0);

    // Restart from DONE with a new corner.
    go5(4, 4);
    check("t44_init_done", if5.done, 0);
    check("t44_init_fail", if5.fail, 0);
    check("t44_init_busy", if5.busy, 1);
    wait5("t44");
    check("t44_done", if5.done, 1);
    check("t44_fail", if5.fail, 0);
    replay5("t44", 4, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
